pipeline_issue_control: RTL and testbench

Issue controller for the in-order CPU pipeline: it decides each cycle whether the instruction in decode may advance into the decode-stage pipeline register. It does this by tracking in-flight register writes in a per-register countdown scoreboard, stalling on read-after-write hazards, and inserting bubbles. It also sequences a fixed branch-flush window after any PC-loading instruction, and supports an orderly halt that drains the pipeline.

---
 rtl/pipeline_issue_control.sv | 130 +++++++++++++
 tb/tb_pipeline_issue_control.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_issue_control.sv
// pipeline_issue_control: decode-stage issue gate for the in-order pipeline.
// Tracks in-flight register writes with per-register countdown counters,
// stalls on read-after-write hazards, sequences the branch-flush window and
// drains the pipeline on a halt request.
module pipeline_issue_control #(
  parameter int unsigned WB_LAT     = 3,
  parameter int unsigned LD_EXTRA   = 1,
  parameter int unsigned BR_PENALTY = 2
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       dec_valid_IN,
  input  logic [2:0] srcA_IN,
  input  logic [2:0] srcB_IN,
  input  logic       useA_IN,
  input  logic       useB_IN,
  input  logic [2:0] writeAd_IN,
  input  logic       write_IN,
  input  logic       adr_mux_IN,
  input  logic       pc_load_IN,
  input  logic       halt_IN,
  output logic       dec_ready_OUT,
  output logic       issue_OUT,
  output logic       stall_OUT,
  output logic       bubble_OUT,
  output logic       flush_OUT,
  output logic       halted_OUT,
  output logic [7:0] pending_OUT
);

  localparam logic [2:0] LAT_ALU = 3'(WB_LAT);
  localparam logic [2:0] LAT_LD  = 3'(WB_LAT + LD_EXTRA);
  localparam logic [2:0] FC_INIT = 3'(BR_PENALTY - 1);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    FLUSH  = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } state_t;

  state_t     state_q;
  logic [2:0] fc_q;
  logic [2:0] cnt_q [8];
  logic [2:0] cnt_d [8];
  logic       hazard;

  // Pending view of the scoreboard and the RAW hazard on the decoded sources.
  always_comb begin
    pending_OUT = '0;
    for (int unsigned r = 0; r < 8; r++) begin
      pending_OUT[r] = (cnt_q[r] != '0);
    end
    hazard = (useA_IN && (cnt_q[srcA_IN] != '0)) ||
             (useB_IN && (cnt_q[srcB_IN] != '0));
  end

  // Issue handshake and derived pipeline-control strobes.
  always_comb begin
    dec_ready_OUT = (state_q == RUN) && !hazard;
    issue_OUT     = dec_valid_IN && dec_ready_OUT;
    stall_OUT     = dec_valid_IN && !dec_ready_OUT && (state_q != FLUSH);
    bubble_OUT    = !issue_OUT;
    flush_OUT     = (state_q == FLUSH);
    halted_OUT    = (state_q == HALTED);
  end

  // Next scoreboard values: countdown, with a writer's load taking priority.
  always_comb begin
    for (int unsigned r = 0; r < 8; r++) begin
      cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - 3'd1 : '0;
    end
    if (issue_OUT && write_IN) begin
      cnt_d[writeAd_IN] = adr_mux_IN ? LAT_LD : LAT_ALU;
    end
  end

  // Scoreboard registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int unsigned r = 0; r < 8; r++) begin
        cnt_q[r] <= '0;
      end
    end else begin
      for (int unsigned r = 0; r < 8; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
    end
  end

  // Issue FSM: run / branch flush window / halt drain / halted.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= RUN;
      fc_q    <= '0;
    end else begin
      case (state_q)
        RUN: begin
          if (issue_OUT && pc_load_IN) begin
            state_q <= FLUSH;
            fc_q    <= FC_INIT;
          end else if (halt_IN) begin
            state_q <= DRAIN;
          end
        end
        FLUSH: begin
          if (fc_q == '0) begin
            state_q <= halt_IN ? DRAIN : RUN;
          end else begin
            fc_q <= fc_q - 3'd1;
          end
        end
        DRAIN: begin
          if (!halt_IN) begin
            state_q <= RUN;
          end else if (pending_OUT == '0) begin
            state_q <= HALTED;
          end
        end
        HALTED: begin
          if (!halt_IN) begin
            state_q <= RUN;
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_issue_control.sv
// Directed bench for pipeline_issue_control (WB_LAT=3, LD_EXTRA=1, BR_PENALTY=2).
module tb_pipeline_issue_control;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       dec_valid_IN;
  logic [2:0] srcA_IN, srcB_IN, writeAd_IN;
  logic       useA_IN, useB_IN, write_IN, adr_mux_IN, pc_load_IN, halt_IN;
  logic       dec_ready_OUT, issue_OUT, stall_OUT, bubble_OUT, flush_OUT, halted_OUT;
  logic [7:0] pending_OUT;

  int total = 0;
  int bad   = 0;

  pipeline_issue_control #(
    .WB_LAT     (3),
    .LD_EXTRA   (1),
    .BR_PENALTY (2)
  ) dut (
    .CLK           (CLK),
    .RST_N         (RST_N),
    .dec_valid_IN  (dec_valid_IN),
    .srcA_IN       (srcA_IN),
    .srcB_IN       (srcB_IN),
    .useA_IN       (useA_IN),
    .useB_IN       (useB_IN),
    .writeAd_IN    (writeAd_IN),
    .write_IN      (write_IN),
    .adr_mux_IN    (adr_mux_IN),
    .pc_load_IN    (pc_load_IN),
    .halt_IN       (halt_IN),
    .dec_ready_OUT (dec_ready_OUT),
    .issue_OUT     (issue_OUT),
    .stall_OUT     (stall_OUT),
    .bubble_OUT    (bubble_OUT),
    .flush_OUT     (flush_OUT),
    .halted_OUT    (halted_OUT),
    .pending_OUT   (pending_OUT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one edge; inputs are then changed and outputs sampled 1 time unit later.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    dec_valid_IN = 0; srcA_IN = 0; srcB_IN = 0; useA_IN = 0; useB_IN = 0;
    writeAd_IN = 0; write_IN = 0; adr_mux_IN = 0; pc_load_IN = 0;
  endtask

  task automatic wr(input logic [2:0] rd, input logic ld);
    idle();
    dec_valid_IN = 1; write_IN = 1; writeAd_IN = rd; adr_mux_IN = ld;
  endtask

  task automatic rd_a(input logic [2:0] rs);
    idle();
    dec_valid_IN = 1; useA_IN = 1; srcA_IN = rs;
  endtask

  initial begin
    idle();
    halt_IN = 0;
    RST_N   = 0;
    #12;
    // reset state
    check("rst_pending", pending_OUT, 8'h00);
    check("rst_ready",   dec_ready_OUT, 1);
    check("rst_bubble",  bubble_OUT, 1);
    check("rst_flush",   flush_OUT, 0);
    check("rst_halted",  halted_OUT, 0);
    check("rst_stall",   stall_OUT, 0);
    dec_valid_IN = 1; #1;
    check("rst_issue_follows_valid", issue_OUT, 1);
    dec_valid_IN = 0;
    #2 RST_N = 1;
    tick();

    // RAW on r2: 3 stall cycles, issue in the 4th
    wr(3'd2, 0); #1;
    check("raw_prod_issue", issue_OUT, 1);
    tick();
    rd_a(3'd2);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("raw_stall", stall_OUT, 1);
      check("raw_noissue", issue_OUT, 0);
      check("raw_pending", pending_OUT, 8'h04);
      tick();
    end
    check("raw_pending_clr", pending_OUT, 8'h00);
    check("raw_issue", issue_OUT, 1);
    check("raw_nostall", stall_OUT, 0);
    tick();

    // load to r5: reader stalls 4 cycles
    wr(3'd5, 1); #1;
    check("ld_issue", issue_OUT, 1);
    tick();
    idle(); dec_valid_IN = 1; useB_IN = 1; srcB_IN = 3'd5;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("ld_stall", stall_OUT, 1);
      tick();
    end
    check("ld_reader_issue", issue_OUT, 1);
    tick();
    // load to r5, reader of r6 issues at once
    wr(3'd5, 1); tick();
    rd_a(3'd6); #1;
    check("ld_indep_issue", issue_OUT, 1);
    check("ld_indep_stall", stall_OUT, 0);
    check("ld_indep_pending", pending_OUT, 8'h20);
    tick();
    idle();
    for (int i = 0; i < 4; i++) tick();
    check("ld_drained", pending_OUT, 8'h00);

    // branch: 2 flush cycles, issue in the 3rd
    idle(); dec_valid_IN = 1; pc_load_IN = 1; #1;
    check("br_issue", issue_OUT, 1);
    tick();
    idle(); dec_valid_IN = 1;
    for (int i = 0; i < 2; i++) begin
      #1;
      check("br_flush", flush_OUT, 1);
      check("br_ready", dec_ready_OUT, 0);
      check("br_nostall", stall_OUT, 0);
      check("br_bubble", bubble_OUT, 1);
      tick();
    end
    check("br_flush_end", flush_OUT, 0);
    check("br_resume", issue_OUT, 1);
    tick();

    // branch with halt raised during the flush -> DRAIN -> HALTED
    idle(); dec_valid_IN = 1; pc_load_IN = 1; tick();
    idle(); halt_IN = 1; #1;
    check("brh_flush1", flush_OUT, 1);
    tick();
    check("brh_flush2", flush_OUT, 1);
    tick();
    dec_valid_IN = 1; #1;
    check("brh_drain_flush", flush_OUT, 0);
    check("brh_drain_ready", dec_ready_OUT, 0);
    check("brh_drain_stall", stall_OUT, 1);
    check("brh_drain_halted", halted_OUT, 0);
    tick();
    check("brh_halted", halted_OUT, 1);
    halt_IN = 0; #1;
    check("brh_halted_held", halted_OUT, 1);
    tick();
    check("brh_run_halted", halted_OUT, 0);
    check("brh_run_ready", dec_ready_OUT, 1);
    idle(); tick();

    // WAW on r3: reload to 3, reader stalls 3 more cycles
    wr(3'd3, 0); tick();
    idle(); tick();
    check("waw_pending", pending_OUT, 8'h08);
    wr(3'd3, 0); #1;
    check("waw_reissue", issue_OUT, 1);
    tick();
    rd_a(3'd3);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("waw_stall", stall_OUT, 1);
      tick();
    end
    check("waw_reader_issue", issue_OUT, 1);
    tick();

    // halt with r1 (alu) and r4 (load) pending
    wr(3'd1, 0); tick();
    wr(3'd4, 1); tick();
    idle(); halt_IN = 1; tick();
    dec_valid_IN = 1;
    begin
      logic [7:0] exp_pend [4];
      exp_pend[0] = 8'h12; exp_pend[1] = 8'h10; exp_pend[2] = 8'h10; exp_pend[3] = 8'h00;
      for (int i = 0; i < 4; i++) begin
        #1;
        check("drn_pending", pending_OUT, exp_pend[i]);
        check("drn_noissue", issue_OUT, 0);
        check("drn_not_halted", halted_OUT, 0);
        tick();
      end
    end
    check("drn_halted", halted_OUT, 1);
    check("drn_halted_ready", dec_ready_OUT, 0);
    check("drn_halted_stall", stall_OUT, 1);
    halt_IN = 0; tick();
    check("drn_run_ready", dec_ready_OUT, 1);
    check("drn_run_issue", issue_OUT, 1);
    check("drn_run_halted", halted_OUT, 0);
    idle(); tick();

    // reset asserted mid-flush, with a pending write from the branch itself
    idle(); dec_valid_IN = 1; pc_load_IN = 1; write_IN = 1; writeAd_IN = 3'd7; tick();
    idle(); #1;
    check("rstf_flush", flush_OUT, 1);
    check("rstf_pending", pending_OUT, 8'h80);
    #1 RST_N = 0; #1;
    check("rstf_flush_clr", flush_OUT, 0);
    check("rstf_pending_clr", pending_OUT, 8'h00);
    check("rstf_ready", dec_ready_OUT, 1);
    #3 RST_N = 1;
    tick();
    check("rstf_after_flush", flush_OUT, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
